// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [2:0] STARVE_MAX = 3'd4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter, present only when MEM_ARB_FAIRNESS_EN is defined.
// Counts load/store wins over a waiting fetch and saturates at STARVE_MAX.
`ifdef MEM_ARB_FAIRNESS_EN
module arb_starve_cnt
    import mem_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starved
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = 3'd0;
        end else if (i_inc && (cnt_q != STARVE_MAX)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_starved = (cnt_q == STARVE_MAX);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto one memory port, one transaction in flight.
// Define MEM_ARB_FAIRNESS_EN to let a starved fetch win contention; otherwise load/store always wins.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,

    input  logic        i_ls_req,
    input  logic        i_ls_wren,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_bmask,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,

    output logic        o_mem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,

    output logic        o_stall,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a requester holds *_req until it sees *_gnt (one cycle, IDLE only);
    // the memory accepts o_mem_req on i_mem_ready and answers reads with one i_mem_rvalid.

    state_e      state_q,     state_d;
    owner_e      owner_q,     owner_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [3:0]  bmask_q,     bmask_d;
    logic        wren_q,      wren_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] ls_rdata_q,  ls_rdata_d;

    logic        if_gnt;
    logic        ls_gnt;
    logic        if_priority;
    logic        ls_wins;

`ifdef MEM_ARB_FAIRNESS_EN
    arb_starve_cnt u_starve_cnt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_inc     (ls_gnt & i_if_req),
        .i_clr     (if_gnt),
        .o_starved (if_priority)
    );
`else
    assign if_priority = 1'b0;
`endif

    assign ls_wins = i_ls_req & ~(i_if_req & if_priority);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        bmask_d     = bmask_q;
        wren_d      = wren_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are combinational so a read returns three cycles after gnt.
                if (!i_reset) begin
                    if (ls_wins) begin
                        ls_gnt  = 1'b1;
                        owner_d = OWN_LS;
                        addr_d  = i_ls_addr;
                        wdata_d = i_ls_wdata;
                        bmask_d = i_ls_bmask;
                        wren_d  = i_ls_wren;
                        state_d = REQ;
                    end else if (i_if_req) begin
                        if_gnt  = 1'b1;
                        owner_d = OWN_IF;
                        addr_d  = i_if_addr;
                        wdata_d = 32'd0;
                        bmask_d = 4'hF;
                        wren_d  = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    if (wren_q) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = 32'd0;
                        state_d     = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (i_mem_rvalid) begin
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = i_mem_rdata;
                    end else begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = i_mem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            bmask_q     <= 4'd0;
            wren_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            ls_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bmask_q     <= bmask_d;
            wren_q      <= wren_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_ls_gnt    = ls_gnt;
    assign o_if_rvalid = if_rvalid_q;
    assign o_ls_rvalid = ls_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rdata  = ls_rdata_q;

    assign o_mem_req   = (state_q == REQ);
    assign o_mem_wren  = (state_q == REQ) & wren_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_bmask = bmask_q;

    assign o_stall     = (state_q != IDLE) | i_if_req | i_ls_req;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, fetch read, contention,
// store with back-pressure, grant ordering under contention, and reset mid-response.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ls_req;
    logic        i_ls_wren;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic        o_ls_gnt;
    logic        o_ls_rvalid;
    logic [31:0] o_ls_rdata;
    logic        o_mem_req;
    logic        o_mem_wren;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_stall;
    logic [1:0]  o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_gnt     (o_if_gnt),
        .o_if_rvalid  (o_if_rvalid),
        .o_if_rdata   (o_if_rdata),
        .i_ls_req     (i_ls_req),
        .i_ls_wren    (i_ls_wren),
        .i_ls_addr    (i_ls_addr),
        .i_ls_wdata   (i_ls_wdata),
        .i_ls_bmask   (i_ls_bmask),
        .o_ls_gnt     (o_ls_gnt),
        .o_ls_rvalid  (o_ls_rvalid),
        .o_ls_rdata   (o_ls_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_wren   (o_mem_wren),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_bmask  (o_mem_bmask),
        .i_mem_ready  (i_mem_ready),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_stall      (o_stall),
        .o_dbg_state  (o_dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_mid();
        @(negedge i_clk);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_if_req     = 1'b1;
        i_if_addr    = 32'h0000_0040;
        i_ls_req     = 1'b0;
        i_ls_wren    = 1'b0;
        i_ls_addr    = 32'd0;
        i_ls_wdata   = 32'd0;
        i_ls_bmask   = 4'd0;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'd0;

        // Reset, with a fetch request pending that must not be granted.
        next_cyc();
        next_cyc();
        wait_mid();
        check_eq("rst_if_gnt",    32'(o_if_gnt),    32'd0);
        check_eq("rst_ls_gnt",    32'(o_ls_gnt),    32'd0);
        check_eq("rst_mem_req",   32'(o_mem_req),   32'd0);
        check_eq("rst_mem_wren",  32'(o_mem_wren),  32'd0);
        check_eq("rst_mem_addr",  o_mem_addr,       32'd0);
        check_eq("rst_mem_bmask", 32'(o_mem_bmask), 32'd0);
        check_eq("rst_if_rvalid", 32'(o_if_rvalid), 32'd0);
        check_eq("rst_ls_rvalid", 32'(o_ls_rvalid), 32'd0);
        check_eq("rst_if_rdata",  o_if_rdata,       32'd0);
        check_eq("rst_ls_rdata",  o_ls_rdata,       32'd0);
        check_eq("rst_state",     32'(o_dbg_state), 32'd0);
        next_cyc();
        i_reset  = 1'b0;
        i_if_req = 1'b0;
        wait_mid();
        check_eq("idle_stall", 32'(o_stall), 32'd0);

        // Fetch read, minimum latency.
        next_cyc();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0100;
        wait_mid();
        check_eq("f_if_gnt", 32'(o_if_gnt), 32'd1);
        check_eq("f_ls_gnt", 32'(o_ls_gnt), 32'd0);
        next_cyc();
        i_if_req    = 1'b0;
        i_if_addr   = 32'hFFFF_FFFF;
        i_mem_ready = 1'b1;
        wait_mid();
        check_eq("f_mem_req",  32'(o_mem_req),   32'd1);
        check_eq("f_mem_wren", 32'(o_mem_wren),  32'd0);
        check_eq("f_mem_addr", o_mem_addr,       32'h0000_0100);
        check_eq("f_state_req", 32'(o_dbg_state), 32'd1);
        check_eq("f_stall_req", 32'(o_stall),     32'd1);
        next_cyc();
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_BEEF;
        wait_mid();
        check_eq("f_state_resp", 32'(o_dbg_state), 32'd2);
        check_eq("f_mem_req_resp", 32'(o_mem_req), 32'd0);
        check_eq("f_if_rvalid_early", 32'(o_if_rvalid), 32'd0);
        next_cyc();
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'd0;
        wait_mid();
        check_eq("f_if_rvalid", 32'(o_if_rvalid), 32'd1);
        check_eq("f_if_rdata",  o_if_rdata,       32'hDEAD_BEEF);
        check_eq("f_ls_rvalid", 32'(o_ls_rvalid), 32'd0);
        check_eq("f_stall_done", 32'(o_stall),    32'd0);
        check_eq("f_state_idle", 32'(o_dbg_state), 32'd0);
        next_cyc();
        wait_mid();
        check_eq("f_if_rvalid_pulse", 32'(o_if_rvalid), 32'd0);
        check_eq("f_if_rdata_hold",   o_if_rdata,       32'hDEAD_BEEF);

        // Contention: load/store read first, fetch on the next IDLE cycle.
        next_cyc();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0300;
        i_ls_req  = 1'b1;
        i_ls_wren = 1'b0;
        i_ls_addr = 32'h0000_0200;
        wait_mid();
        check_eq("c_ls_gnt", 32'(o_ls_gnt), 32'd1);
        check_eq("c_if_gnt", 32'(o_if_gnt), 32'd0);
        next_cyc();
        i_ls_req    = 1'b0;
        i_mem_ready = 1'b1;
        wait_mid();
        check_eq("c_if_gnt_busy", 32'(o_if_gnt), 32'd0);
        check_eq("c_mem_addr",    o_mem_addr,    32'h0000_0200);
        next_cyc();
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hCAFE_0001;
        wait_mid();
        check_eq("c_if_gnt_resp", 32'(o_if_gnt), 32'd0);
        next_cyc();
        i_mem_rvalid = 1'b0;
        wait_mid();
        check_eq("c_ls_rvalid", 32'(o_ls_rvalid), 32'd1);
        check_eq("c_ls_rdata",  o_ls_rdata,       32'hCAFE_0001);
        check_eq("c_if_rvalid", 32'(o_if_rvalid), 32'd0);
        check_eq("c_if_gnt2",   32'(o_if_gnt),    32'd1);
        next_cyc();
        i_if_req     = 1'b0;
        i_mem_ready  = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBAD0_BAD0;
        wait_mid();
        check_eq("c_mem_addr_if", o_mem_addr, 32'h0000_0300);
        next_cyc();
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        wait_mid();
        check_eq("c_rvalid_in_req_ignored", 32'(o_if_rvalid), 32'd0);
        check_eq("c_state_resp", 32'(o_dbg_state), 32'd2);
        next_cyc();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h1111_2222;
        wait_mid();
        next_cyc();
        i_mem_rvalid = 1'b0;
        wait_mid();
        check_eq("c_if_rvalid2", 32'(o_if_rvalid), 32'd1);
        check_eq("c_if_rdata2",  o_if_rdata,       32'h1111_2222);
        check_eq("c_ls_rdata_hold", o_ls_rdata,    32'hCAFE_0001);
        check_eq("c_ls_rvalid2", 32'(o_ls_rvalid), 32'd0);

        // Store with ready held low for three cycles.
        next_cyc();
        i_ls_req   = 1'b1;
        i_ls_wren  = 1'b1;
        i_ls_addr  = 32'h0000_7000;
        i_ls_wdata = 32'h1234_5678;
        i_ls_bmask = 4'hF;
        wait_mid();
        check_eq("s_ls_gnt", 32'(o_ls_gnt), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            next_cyc();
            i_ls_req    = 1'b0;
            i_ls_wren   = 1'b0;
            i_ls_addr   = 32'hAAAA_AAAA;
            i_ls_wdata  = 32'h5555_5555;
            i_ls_bmask  = 4'h3;
            i_mem_ready = (k == 4);
            wait_mid();
            check_eq("s_mem_req",   32'(o_mem_req),   32'd1);
            check_eq("s_mem_wren",  32'(o_mem_wren),  32'd1);
            check_eq("s_mem_addr",  o_mem_addr,       32'h0000_7000);
            check_eq("s_mem_wdata", o_mem_wdata,      32'h1234_5678);
            check_eq("s_mem_bmask", 32'(o_mem_bmask), 32'hF);
            check_eq("s_ls_rvalid_early", 32'(o_ls_rvalid), 32'd0);
        end
        next_cyc();
        i_mem_ready = 1'b0;
        wait_mid();
        check_eq("s_ls_rvalid", 32'(o_ls_rvalid), 32'd1);
        check_eq("s_ls_rdata",  o_ls_rdata,       32'd0);
        check_eq("s_mem_req_off",  32'(o_mem_req),  32'd0);
        check_eq("s_mem_wren_off", 32'(o_mem_wren), 32'd0);
        check_eq("s_stall_off",    32'(o_stall),    32'd0);

        // Both requests held continuously: grant order.
        next_cyc();
        i_if_req   = 1'b1;
        i_if_addr  = 32'h0000_0400;
        i_ls_req   = 1'b1;
        i_ls_wren  = 1'b0;
        i_ls_addr  = 32'h0000_0500;
        i_ls_bmask = 4'hF;
        for (int g = 0; g < 6; g++) begin
            logic exp_if;
`ifdef MEM_ARB_FAIRNESS_EN
            exp_if = (g == 4);
`else
            exp_if = 1'b0;
`endif
            wait_mid();
            check_eq($sformatf("q_if_gnt_%0d", g), 32'(o_if_gnt), 32'(exp_if));
            check_eq($sformatf("q_ls_gnt_%0d", g), 32'(o_ls_gnt), 32'(!exp_if));
            next_cyc();
            i_mem_ready = 1'b1;
            next_cyc();
            i_mem_ready  = 1'b0;
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = 32'h0000_1000 + 32'(g);
            if (g == 5) begin
                i_if_req = 1'b0;
                i_ls_req = 1'b0;
            end
            next_cyc();
            i_mem_rvalid = 1'b0;
        end
        wait_mid();
        check_eq("q_last_ls_rdata", o_ls_rdata, 32'h0000_1005);

        // Reset during RESP, then a late rvalid.
        next_cyc();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0800;
        wait_mid();
        check_eq("r_if_gnt", 32'(o_if_gnt), 32'd1);
        next_cyc();
        i_if_req    = 1'b0;
        i_mem_ready = 1'b1;
        next_cyc();
        i_mem_ready = 1'b0;
        i_reset     = 1'b1;
        wait_mid();
        check_eq("r_state_resp", 32'(o_dbg_state), 32'd2);
        next_cyc();
        i_reset = 1'b0;
        wait_mid();
        check_eq("r_state_idle", 32'(o_dbg_state), 32'd0);
        next_cyc();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h5555_5555;
        next_cyc();
        i_mem_rvalid = 1'b0;
        wait_mid();
        check_eq("r_if_rvalid", 32'(o_if_rvalid), 32'd0);
        check_eq("r_ls_rvalid", 32'(o_ls_rvalid), 32'd0);
        check_eq("r_if_rdata",  o_if_rdata,       32'd0);
        check_eq("r_state",     32'(o_dbg_state), 32'd0);
        check_eq("r_stall",     32'(o_stall),     32'd0);
        next_cyc();
        wait_mid();
        check_eq("r_if_rvalid_late", 32'(o_if_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
